// File: rtl/pulse_to_press.sv
// Turns single-cycle event pulses into button-style active-low presses:
// press_n low for HOLD_CYCLES, then high for GAP_CYCLES, with a saturating queue of requests.
module pulse_to_press #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              press_n,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // state | meaning
  // IDLE  | no press in progress, press_n released
  // HOLD  | press_n driven low, counting HOLD_CYCLES
  // GAP   | press_n released, counting GAP_CYCLES before the next press
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0]       HOLD_LD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]       GAP_LD   = 16'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                press_n_q;
  logic                busy_q;
  logic                start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        start = pulse_in || (pend_q != '0);
      end
      HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == 16'd0) begin
          if (pulse_in || (pend_q != '0)) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // A consuming edge takes one request; an arrival on the same edge replaces it.
    if (start) begin
      state_d = HOLD;
      cnt_d   = HOLD_LD;
      if (pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1) + PEND_W'(pulse_in);
      end
    end else if ((state_q != IDLE) && pulse_in) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      press_n_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      press_n_q <= (state_q != HOLD);
      busy_q    <= (state_q != IDLE);
    end
  end

  assign press_n  = press_n_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_to_press.sv
// Self-checking bench for pulse_to_press: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a press-position model.
module tb_pulse_to_press;
  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pulse_in = 1'b0;
  logic          press_n;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int fall_cnt = 0;
  logic prev_pn = 1'b1;
  bit chk_en = 1'b0;

  // model: a press occupies positions 0..H+G-1; positions below H are the low phase
  bit m_active = 1'b0;
  int m_pos    = 0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;
  bit m_pn     = 1'b1;
  bit m_busy   = 1'b0;

  always #5 clk = ~clk;

  pulse_to_press #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .PEND_W      (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .press_n  (press_n),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    bit a, st, o;
    int p, pe;
    if (!rst) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_pend   <= 0;
      m_ovf    <= 1'b0;
      m_pn     <= 1'b1;
      m_busy   <= 1'b0;
      chk_en   <= 1'b1;
    end else begin
      a  = m_active;
      p  = m_pos;
      pe = m_pend;
      o  = 1'b0;
      st = 1'b0;
      if (!a) begin
        st = pulse_in || (pe > 0);
      end else if (p == H + G - 1) begin
        if (pulse_in || (pe > 0)) st = 1'b1;
        else a = 1'b0;
      end else begin
        p = p + 1;
        if (pulse_in) begin
          if (pe == PMAX) o = 1'b1;
          else pe = pe + 1;
        end
      end
      if (st) begin
        a = 1'b1;
        p = 0;
        if (pe > 0) pe = pe - 1 + int'(pulse_in);
      end
      m_pn     <= !(m_active && (m_pos < H));
      m_busy   <= m_active;
      m_active <= a;
      m_pos    <= p;
      m_pend   <= pe;
      m_ovf    <= o;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model press_n", 32'(press_n), 32'(m_pn));
      chk("model busy", 32'(busy), 32'(m_busy));
      chk("model pending", 32'(pending), 32'(m_pend));
      chk("model overflow", 32'(overflow), 32'(m_ovf));
      if (prev_pn === 1'b1 && press_n === 1'b0) fall_cnt++;
      prev_pn = press_n;
    end
  end

  task automatic step(input bit p, input bit r = 1'b1);
    pulse_in = p;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int f0;
    int dens;
    // reset with pulse_in toggling
    step(1'b1, 1'b0);
    chk("rst press_n", 32'(press_n), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst pending", 32'(pending), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    step(1'b0, 1'b0);
    chk("rst2 press_n", 32'(press_n), 32'd1);
    chk("rst2 busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      chk("post-rst press_n", 32'(press_n), 32'd1);
      chk("post-rst busy", 32'(busy), 32'd0);
    end

    // single press: pulse at edge k
    step(1'b1);
    chk("single k press_n", 32'(press_n), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      chk("single press_n", 32'(press_n), (i <= H) ? 32'd0 : 32'd1);
      chk("single busy", 32'(busy), (i <= H + G) ? 32'd1 : 32'd0);
      chk("single pending", 32'(pending), 32'd0);
    end

    // back-to-back pulses at k, k+1, k+2
    step(1'b1);
    step(1'b1);
    chk("b2b pending k+1", 32'(pending), 32'd1);
    step(1'b1);
    chk("b2b pending k+2", 32'(pending), 32'd2);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("b2b pending k+5", 32'(pending), 32'd2);
    chk("b2b press_n k+5", 32'(press_n), 32'd1);
    step(1'b0);
    chk("b2b pending k+6", 32'(pending), 32'd1);
    step(1'b0);
    chk("b2b press_n k+7", 32'(press_n), 32'd0);
    for (int i = 8; i <= 18; i++) step(1'b0);
    chk("b2b busy k+18", 32'(busy), 32'd1);
    chk("b2b pending k+18", 32'(pending), 32'd0);
    step(1'b0);
    chk("b2b busy k+19", 32'(busy), 32'd0);

    // overflow: five pulses from idle
    f0 = fall_cnt;
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("ovf pending k+3", 32'(pending), 32'd3);
    chk("ovf flag k+3", 32'(overflow), 32'd0);
    step(1'b1);
    chk("ovf flag k+4", 32'(overflow), 32'd1);
    chk("ovf pending k+4", 32'(pending), 32'd3);
    step(1'b0);
    chk("ovf flag k+5", 32'(overflow), 32'd0);
    for (int i = 0; i < 30; i++) step(1'b0);
    chk("ovf press count", 32'(fall_cnt - f0), 32'd4);
    chk("ovf idle busy", 32'(busy), 32'd0);

    // reset in the middle of a press with two queued
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("midrst pending before", 32'(pending), 32'd2);
    step(1'b0, 1'b0);
    chk("midrst press_n", 32'(press_n), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst pending", 32'(pending), 32'd0);
    f0 = fall_cnt;
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("midrst no presses", 32'(fall_cnt - f0), 32'd0);

    // chaining: new request exactly on the last gap edge
    f0 = fall_cnt;
    step(1'b1);
    for (int i = 1; i <= 5; i++) step(1'b0);
    step(1'b1);
    chk("chain press_n k+6", 32'(press_n), 32'd1);
    chk("chain busy k+6", 32'(busy), 32'd1);
    chk("chain pending k+6", 32'(pending), 32'd0);
    step(1'b0);
    chk("chain press_n k+7", 32'(press_n), 32'd0);
    chk("chain busy k+7", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("chain press count", 32'(fall_cnt - f0), 32'd2);

    // randomized traffic with varying density and rare resets
    for (int blk = 0; blk < 8; blk++) begin
      dens = $urandom_range(5, 90);
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < dens, $urandom_range(0, 299) != 0);
      end
    end
    for (int i = 0; i < 40; i++) step(1'b0);
    chk("final idle busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
